// File: rtl/diferential_muxpga_grid.sv
// ---------------------------------------------------------------------------
// diferential_muxpga_grid
//
// ROWS x COLS torus of BITS-wide registered logic cells. Each cell owns a
// 6-bit configuration field {func[1:0], sel2[1:0], sel1[1:0]} taken from a
// serial configuration chain. A small IDLE/LOAD/RUN state machine controls
// loading and execution. Row 0 takes its north and northwest inputs from
// data_in; column COLS-1 drives data_out. Columns wrap, rows do not.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   cfg_start  request (re)configuration, honoured in IDLE and RUN
//   cfg_valid  cfg_data carries a configuration bit (LOAD only)
//   cfg_data   serial configuration bit, first bit sent ends at CFG[N-1]
//   run_en     cells update this cycle (RUN only)
//   data_in    external north input to row 0
//   data_out   q of cell (r, COLS-1) at bits [r*BITS +: BITS]
//   running    high while in RUN
//   cfg_done   one-cycle pulse on LOAD -> RUN
//   cyc_count  saturating count of RUN cycles with run_en since last LOAD
// ---------------------------------------------------------------------------
module diferential_muxpga_grid #(
  parameter int ROWS  = 6,
  parameter int COLS  = 6,
  parameter int BITS  = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic                   cfg_data,
  input  logic                   run_en,
  input  logic [BITS-1:0]        data_in,
  output logic [ROWS*BITS-1:0]   data_out,
  output logic                   running,
  output logic                   cfg_done,
  output logic [CNT_W-1:0]       cyc_count
);

  localparam int CELLS = ROWS * COLS;
  localparam int N     = CELLS * 6;
  localparam int BCW   = $clog2(N);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    cfg;
  logic [BCW-1:0]  bit_cnt;

  // Cell k = row*COLS + col.
  logic [BITS-1:0] q   [CELLS];
  logic [BITS-1:0] nxt [CELLS];

  logic enter_load;
  logic update;

  // Entering LOAD clears the cells on the same edge the state changes, so
  // q = 0 is visible from the first LOAD cycle.
  assign enter_load = cfg_start && (state == IDLE || state == RUN);
  // cfg_start in RUN wins over run_en: no cell update on that edge.
  assign update     = (state == RUN) && run_en && !cfg_start;

  // NOTE: every case path assigns the result (default included), so these
  // functions and the logic built from them can never infer a latch.
  function automatic logic [BITS-1:0] pick(
    input logic [1:0]      sel,
    input logic [BITS-1:0] n,
    input logic [BITS-1:0] nw,
    input logic [BITS-1:0] w,
    input logic [BITS-1:0] e
  );
    case (sel)
      2'd0:    pick = n;
      2'd1:    pick = nw;
      2'd2:    pick = w;
      default: pick = e;
    endcase
  endfunction

  function automatic logic [BITS-1:0] apply_func(
    input logic [1:0]      f,
    input logic [BITS-1:0] a,
    input logic [BITS-1:0] b
  );
    case (f)
      2'd0:    apply_func = a & b;
      2'd1:    apply_func = a | b;
      2'd2:    apply_func = a ^ b;
      default: apply_func = a + b;   // wraps mod 2^BITS
    endcase
  endfunction

  // Per-cell neighbour selection and next-value computation.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int K  = r * COLS + c;
      localparam int KW = r * COLS + (c + COLS - 1) % COLS;  // west, wrapped
      localparam int KE = r * COLS + (c + 1) % COLS;         // east, wrapped

      logic [BITS-1:0] north;
      logic [BITS-1:0] nwest;
      logic [5:0]      cell_cfg;

      if (r == 0) begin : g_edge
        assign north = data_in;
        assign nwest = data_in;
      end else begin : g_inner
        assign north = q[K - COLS];
        assign nwest = q[KW - COLS];
      end

      assign cell_cfg = cfg[6*K +: 6];
      assign nxt[K]   = apply_func(cell_cfg[5:4],
                          pick(cell_cfg[1:0], north, nwest, q[KW], q[KE]),
                          pick(cell_cfg[3:2], north, nwest, q[KW], q[KE]));

      if (c == COLS - 1) begin : g_out
        assign data_out[r*BITS +: BITS] = q[K];
      end
    end
  end

  // Cell registers.
  // NOTE: the cell array is reset explicitly because its reset value is
  // architecturally visible on data_out; this is plain flops, not a RAM.
  always_ff @(posedge clk) begin
    if (reset || enter_load) begin
      for (int i = 0; i < CELLS; i++) q[i] <= '0;
    end else if (update) begin
      for (int i = 0; i < CELLS; i++) q[i] <= nxt[i];
    end
  end

  // Control state machine with registered status outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cfg       <= '0;
      bit_cnt   <= '0;
      cyc_count <= '0;
      running   <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state     <= LOAD;
            bit_cnt   <= '0;
            cyc_count <= '0;
          end
        end
        LOAD: begin
          // cfg_start is ignored here; the bit counter holds through gaps.
          if (cfg_valid) begin
            cfg <= {cfg[N-2:0], cfg_data};
            if (bit_cnt == LAST_BIT) begin
              state    <= RUN;
              running  <= 1'b1;
              cfg_done <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (cfg_start) begin
            state     <= LOAD;
            running   <= 1'b0;
            bit_cnt   <= '0;
            cyc_count <= '0;
          end else if (run_en && cyc_count != '1) begin
            cyc_count <= cyc_count + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
